load_store_queue: RTL and testbench

// In-order queue of dispatched load/store ops, directly upstream of the data-memory controller.

---
 rtl/load_store_queue_pkg.sv | 34 +++
 rtl/load_store_queue_wakeup.sv | 24 ++
 rtl/load_store_queue.sv | 188 ++++++++++++++++++
 tb/tb_load_store_queue.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/load_store_queue_pkg.sv
// Types shared by the load/store queue and its memory-controller interface.
// Latency: n/a (types only).
// Backpressure: n/a.
package load_store_queue_pkg;

    localparam int LSQ_DEPTH_BITS = 3;
    localparam int ROB_ID_W       = 5;

    typedef struct packed {
        logic                valid;
        logic                mem_inst;
        logic                l_s;
        logic [2:0]          funct3;
        logic [31:0]         rs1_v;
        logic [31:0]         rs2_v;
        logic [31:0]         ls_imm;
        logic [ROB_ID_W-1:0] rob_id_dest;
    } ls_q_entry;

    typedef struct packed {
        logic                valid;
        logic                l_s;
        logic [2:0]          funct3;
        logic [31:0]         imm;
        logic [ROB_ID_W-1:0] rob_id;
        logic                rs1_rdy;
        logic [ROB_ID_W-1:0] rs1_tag;
        logic [31:0]         rs1_v;
        logic                rs2_rdy;
        logic [ROB_ID_W-1:0] rs2_tag;
        logic [31:0]         rs2_v;
    } lsq_slot_t;

endpackage

// File: rtl/load_store_queue_wakeup.sv
// One-operand CDB wakeup: tag compare and value capture mux.
// Latency: purely combinational.
// Backpressure: none.
module lsq_wakeup #(
    parameter int TAG_W = 5
) (
    input  logic             op_rdy,
    input  logic [TAG_W-1:0] op_tag,
    input  logic [31:0]      op_v,
    input  logic             cdb_valid,
    input  logic [TAG_W-1:0] cdb_rob_id,
    input  logic [31:0]      cdb_data,
    output logic             rdy_out,
    output logic [31:0]      v_out
);

    logic hit;

    // Only a still-waiting operand may be overwritten by the broadcast.
    assign hit     = !op_rdy && cdb_valid && (op_tag == cdb_rob_id);
    assign rdy_out = op_rdy | hit;
    assign v_out   = hit ? cdb_data : op_v;

endmodule

// File: rtl/load_store_queue.sv
// In-order load/store queue with CDB operand wakeup, issuing the head op to the memory controller.
// Latency: dispatch-to-issue pulse is two edges when operands are ready at dispatch.
// Backpressure: dispatch dropped when full (unless head issues); issue held off by in_flight_mem.
module load_store_queue
    import load_store_queue_pkg::*;
#(
    parameter int DEPTH_BITS     = LSQ_DEPTH_BITS,
    parameter int ROB_DEPTH_BITS = ROB_ID_W
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      disp_valid,
    input  logic                      disp_l_s,
    input  logic [2:0]                disp_funct3,
    input  logic [31:0]               disp_imm,
    input  logic [ROB_DEPTH_BITS-1:0] disp_rob_id,
    input  logic                      disp_rs1_rdy,
    input  logic [ROB_DEPTH_BITS-1:0] disp_rs1_tag,
    input  logic [31:0]               disp_rs1_v,
    input  logic                      disp_rs2_rdy,
    input  logic [ROB_DEPTH_BITS-1:0] disp_rs2_tag,
    input  logic [31:0]               disp_rs2_v,
    input  logic                      cdb_valid,
    input  logic [ROB_DEPTH_BITS-1:0] cdb_rob_id,
    input  logic [31:0]               cdb_data,
    input  logic                      flush,
    input  logic                      in_flight_mem,
    output ls_q_entry                 ls_q_out,
    output logic                      lsq_full,
    output logic                      lsq_empty
);

    localparam int DEPTH = 1 << DEPTH_BITS;
    localparam int CW    = DEPTH_BITS + 1;

    lsq_slot_t           slot_q [DEPTH];
    lsq_slot_t           slot_d [DEPTH];
    logic [DEPTH_BITS-1:0] head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]       count_q, count_d;
    logic                issued_q, issued_d;
    ls_q_entry           out_q, out_d;

    logic                wk_rs1_rdy [DEPTH];
    logic [31:0]         wk_rs1_v   [DEPTH];
    logic                wk_rs2_rdy [DEPTH];
    logic [31:0]         wk_rs2_v   [DEPTH];
    logic                byp_rs1_rdy, byp_rs2_rdy;
    logic [31:0]         byp_rs1_v, byp_rs2_v;

    lsq_slot_t           head_slot;
    lsq_slot_t           new_slot;
    logic                issue;
    logic                accept;

    for (genvar g = 0; g < DEPTH; g++) begin : g_slot_wk
        lsq_wakeup #(.TAG_W(ROB_DEPTH_BITS)) u_wk_rs1 (
            .op_rdy     (slot_q[g].rs1_rdy),
            .op_tag     (slot_q[g].rs1_tag),
            .op_v       (slot_q[g].rs1_v),
            .cdb_valid  (cdb_valid),
            .cdb_rob_id (cdb_rob_id),
            .cdb_data   (cdb_data),
            .rdy_out    (wk_rs1_rdy[g]),
            .v_out      (wk_rs1_v[g])
        );
        lsq_wakeup #(.TAG_W(ROB_DEPTH_BITS)) u_wk_rs2 (
            .op_rdy     (slot_q[g].rs2_rdy),
            .op_tag     (slot_q[g].rs2_tag),
            .op_v       (slot_q[g].rs2_v),
            .cdb_valid  (cdb_valid),
            .cdb_rob_id (cdb_rob_id),
            .cdb_data   (cdb_data),
            .rdy_out    (wk_rs2_rdy[g]),
            .v_out      (wk_rs2_v[g])
        );
    end

    // Dispatch bypass: an op whose producer broadcasts this very cycle is written already ready.
    lsq_wakeup #(.TAG_W(ROB_DEPTH_BITS)) u_byp_rs1 (
        .op_rdy     (disp_rs1_rdy),
        .op_tag     (disp_rs1_tag),
        .op_v       (disp_rs1_v),
        .cdb_valid  (cdb_valid),
        .cdb_rob_id (cdb_rob_id),
        .cdb_data   (cdb_data),
        .rdy_out    (byp_rs1_rdy),
        .v_out      (byp_rs1_v)
    );
    lsq_wakeup #(.TAG_W(ROB_DEPTH_BITS)) u_byp_rs2 (
        .op_rdy     (disp_rs2_rdy),
        .op_tag     (disp_rs2_tag),
        .op_v       (disp_rs2_v),
        .cdb_valid  (cdb_valid),
        .cdb_rob_id (cdb_rob_id),
        .cdb_data   (cdb_data),
        .rdy_out    (byp_rs2_rdy),
        .v_out      (byp_rs2_v)
    );

    assign lsq_full  = (count_q == CW'(DEPTH));
    assign lsq_empty = (count_q == '0);
    assign ls_q_out  = out_q;

    always_comb begin
        slot_d    = slot_q;
        head_d    = head_q;
        tail_d    = tail_q;
        out_d     = out_q;
        out_d.valid = 1'b0;
        head_slot = slot_q[head_q];

        // issued_q blocks the cycle before the controller can raise in_flight_mem.
        issue  = head_slot.valid && head_slot.rs1_rdy && head_slot.rs2_rdy &&
                 !in_flight_mem && !issued_q && !flush;
        accept = disp_valid && !flush && (!lsq_full || issue);

        new_slot.valid   = 1'b1;
        new_slot.l_s     = disp_l_s;
        new_slot.funct3  = disp_funct3;
        new_slot.imm     = disp_imm;
        new_slot.rob_id  = disp_rob_id;
        new_slot.rs1_rdy = byp_rs1_rdy;
        new_slot.rs1_tag = disp_rs1_tag;
        new_slot.rs1_v   = byp_rs1_v;
        new_slot.rs2_rdy = byp_rs2_rdy;
        new_slot.rs2_tag = disp_rs2_tag;
        new_slot.rs2_v   = byp_rs2_v;

        for (int i = 0; i < DEPTH; i++) begin
            slot_d[i].rs1_rdy = wk_rs1_rdy[i];
            slot_d[i].rs1_v   = wk_rs1_v[i];
            slot_d[i].rs2_rdy = wk_rs2_rdy[i];
            slot_d[i].rs2_v   = wk_rs2_v[i];
        end

        if (issue) begin
            out_d.valid       = 1'b1;
            out_d.mem_inst    = 1'b1;
            out_d.l_s         = head_slot.l_s;
            out_d.funct3      = head_slot.funct3;
            out_d.rs1_v       = head_slot.rs1_v;
            out_d.rs2_v       = head_slot.rs2_v;
            out_d.ls_imm      = head_slot.imm;
            out_d.rob_id_dest = head_slot.rob_id;
            slot_d[head_q].valid = 1'b0;
            head_d = head_q + 1'b1;
        end

        // When full, tail == head: the write lands after the head clear above.
        if (accept) begin
            slot_d[tail_q] = new_slot;
            tail_d = tail_q + 1'b1;
        end

        count_d  = count_q + CW'(accept) - CW'(issue);
        issued_d = issue;

        if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                slot_d[i].valid = 1'b0;
            end
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                slot_q[i] <= '0;
            end
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            issued_q <= 1'b0;
            out_q    <= '0;
        end else begin
            slot_q   <= slot_d;
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
            issued_q <= issued_d;
            out_q    <= out_d;
        end
    end

endmodule

// File: tb/tb_load_store_queue.sv
// Bench for load_store_queue: directed scenarios plus random traffic against a queue-based model.
module tb_load_store_queue;
    import load_store_queue_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        disp_valid, disp_l_s;
    logic [2:0]  disp_funct3;
    logic [31:0] disp_imm;
    logic [4:0]  disp_rob_id;
    logic        disp_rs1_rdy, disp_rs2_rdy;
    logic [4:0]  disp_rs1_tag, disp_rs2_tag;
    logic [31:0] disp_rs1_v, disp_rs2_v;
    logic        cdb_valid;
    logic [4:0]  cdb_rob_id;
    logic [31:0] cdb_data;
    logic        flush, in_flight_mem;
    ls_q_entry   ls_q_out;
    logic        lsq_full, lsq_empty;

    always #5 clk = ~clk;

    load_store_queue dut (
        .clk(clk), .rst_n(rst_n),
        .disp_valid(disp_valid), .disp_l_s(disp_l_s), .disp_funct3(disp_funct3),
        .disp_imm(disp_imm), .disp_rob_id(disp_rob_id),
        .disp_rs1_rdy(disp_rs1_rdy), .disp_rs1_tag(disp_rs1_tag), .disp_rs1_v(disp_rs1_v),
        .disp_rs2_rdy(disp_rs2_rdy), .disp_rs2_tag(disp_rs2_tag), .disp_rs2_v(disp_rs2_v),
        .cdb_valid(cdb_valid), .cdb_rob_id(cdb_rob_id), .cdb_data(cdb_data),
        .flush(flush), .in_flight_mem(in_flight_mem),
        .ls_q_out(ls_q_out), .lsq_full(lsq_full), .lsq_empty(lsq_empty)
    );

    typedef struct {
        logic        l_s;
        logic [2:0]  f3;
        logic [31:0] imm;
        logic [4:0]  rob;
        logic        r1;
        logic [4:0]  t1;
        logic [31:0] v1;
        logic        r2;
        logic [4:0]  t2;
        logic [31:0] v2;
    } op_t;

    op_t       mq[$];
    ls_q_entry m_out;
    logic      m_issued;
    int        errors = 0;
    int        checks = 0;

    // Reference: program-order list of ops; head issues when ready and the port is free.
    task automatic model_clock();
        op_t  n;
        logic iss, acc;
        iss = (mq.size() > 0) && mq[0].r1 && mq[0].r2 && !in_flight_mem && !m_issued && !flush;
        acc = disp_valid && !flush && ((mq.size() < 8) || iss);
        n.l_s = disp_l_s; n.f3 = disp_funct3; n.imm = disp_imm; n.rob = disp_rob_id;
        n.r1 = disp_rs1_rdy; n.t1 = disp_rs1_tag; n.v1 = disp_rs1_v;
        n.r2 = disp_rs2_rdy; n.t2 = disp_rs2_tag; n.v2 = disp_rs2_v;
        if (cdb_valid && !n.r1 && n.t1 == cdb_rob_id) begin n.r1 = 1'b1; n.v1 = cdb_data; end
        if (cdb_valid && !n.r2 && n.t2 == cdb_rob_id) begin n.r2 = 1'b1; n.v2 = cdb_data; end
        m_out.valid = 1'b0;
        if (iss) begin
            m_out.valid = 1'b1; m_out.mem_inst = 1'b1; m_out.l_s = mq[0].l_s;
            m_out.funct3 = mq[0].f3; m_out.rs1_v = mq[0].v1; m_out.rs2_v = mq[0].v2;
            m_out.ls_imm = mq[0].imm; m_out.rob_id_dest = mq[0].rob;
            void'(mq.pop_front());
        end
        foreach (mq[i]) begin
            if (cdb_valid && !mq[i].r1 && mq[i].t1 == cdb_rob_id) begin mq[i].r1 = 1'b1; mq[i].v1 = cdb_data; end
            if (cdb_valid && !mq[i].r2 && mq[i].t2 == cdb_rob_id) begin mq[i].r2 = 1'b1; mq[i].v2 = cdb_data; end
        end
        m_issued = iss;
        if (flush) mq.delete();
        else if (acc) mq.push_back(n);
    endtask

    task automatic step();
        model_clock();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        disp_valid = 0; disp_l_s = 0; disp_funct3 = 0; disp_imm = 0; disp_rob_id = 0;
        disp_rs1_rdy = 1; disp_rs1_tag = 0; disp_rs1_v = 0;
        disp_rs2_rdy = 1; disp_rs2_tag = 0; disp_rs2_v = 0;
        cdb_valid = 0; cdb_rob_id = 0; cdb_data = 0; flush = 0;
    endtask

    task automatic dispatch(input logic ls, input logic [4:0] rob, input logic r1, input logic [4:0] t1,
                            input logic [31:0] v1, input logic r2, input logic [4:0] t2,
                            input logic [31:0] v2, input logic [31:0] imm);
        disp_valid = 1; disp_l_s = ls; disp_funct3 = 3'($urandom_range(0, 7)); disp_rob_id = rob;
        disp_rs1_rdy = r1; disp_rs1_tag = t1; disp_rs1_v = v1;
        disp_rs2_rdy = r2; disp_rs2_tag = t2; disp_rs2_v = v2; disp_imm = imm;
    endtask

    task automatic model_reset();
        mq.delete();
        m_out = '0;
        m_issued = 1'b0;
    endtask

    task automatic test_reset();
        idle(); in_flight_mem = 0; rst_n = 0; model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (ls_q_out.valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", ls_q_out.valid); end
        checks++; if (lsq_empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b want 1", lsq_empty); end
        checks++; if (lsq_full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b want 0", lsq_full); end
        rst_n = 1;
    endtask

    task automatic test_load_issue();
        dispatch(1'b1, 5'd3, 1'b1, 5'd0, 32'h1000, 1'b1, 5'd0, 32'h0, 32'd4);
        step(); idle();
        checks++; if (ls_q_out !== m_out || lsq_empty !== 1'b0) begin errors++; $display("FAIL lw_wait: got %h/%b want %h/0", ls_q_out, lsq_empty, m_out); end
        step();
        checks++; if (ls_q_out !== m_out) begin errors++; $display("FAIL lw_model: got %h want %h", ls_q_out, m_out); end
        checks++;
        if (ls_q_out.valid !== 1'b1 || ls_q_out.l_s !== 1'b1 || ls_q_out.rob_id_dest !== 5'd3 ||
            ls_q_out.rs1_v !== 32'h1000 || ls_q_out.ls_imm !== 32'd4 || ls_q_out.mem_inst !== 1'b1) begin
            errors++; $display("FAIL lw_issue: got %h want valid l_s rob=3 rs1=1000 imm=4", ls_q_out);
        end
        step();
        checks++; if (ls_q_out.valid !== 1'b0 || lsq_empty !== 1'b1) begin errors++; $display("FAIL lw_pulse: got valid=%b empty=%b want 0/1", ls_q_out.valid, lsq_empty); end
    endtask

    task automatic test_cdb_wakeup();
        dispatch(1'b0, 5'd5, 1'b1, 5'd0, 32'h2000, 1'b0, 5'd7, 32'h0, 32'd8);
        step(); idle();
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (ls_q_out.valid !== 1'b0 || ls_q_out !== m_out) begin errors++; $display("FAIL sw_blocked: got %h want %h", ls_q_out, m_out); end
        end
        cdb_valid = 1; cdb_rob_id = 5'd7; cdb_data = 32'hDEADBEEF;
        step(); idle();
        checks++; if (ls_q_out.valid !== 1'b0) begin errors++; $display("FAIL sw_wake_edge: got %b want 0", ls_q_out.valid); end
        step();
        checks++; if (ls_q_out !== m_out) begin errors++; $display("FAIL sw_model: got %h want %h", ls_q_out, m_out); end
        checks++;
        if (ls_q_out.valid !== 1'b1 || ls_q_out.rs2_v !== 32'hDEADBEEF || ls_q_out.l_s !== 1'b0 || ls_q_out.rob_id_dest !== 5'd5) begin
            errors++; $display("FAIL sw_issue: got %h want valid rs2=deadbeef store rob=5", ls_q_out);
        end
        step();
    endtask

    task automatic test_bypass();
        dispatch(1'b1, 5'd10, 1'b0, 5'd9, 32'h0, 1'b1, 5'd0, 32'h0, 32'd12);
        cdb_valid = 1; cdb_rob_id = 5'd9; cdb_data = 32'h55;
        step(); idle();
        step();
        checks++; if (ls_q_out !== m_out) begin errors++; $display("FAIL byp_model: got %h want %h", ls_q_out, m_out); end
        checks++; if (ls_q_out.valid !== 1'b1 || ls_q_out.rs1_v !== 32'h55) begin errors++; $display("FAIL byp_issue: got valid=%b rs1=%h want 1/55", ls_q_out.valid, ls_q_out.rs1_v); end
        step();
    endtask

    task automatic test_full_wrap();
        in_flight_mem = 1;
        for (int i = 0; i < 9; i++) begin
            dispatch(1'($urandom), 5'(16 + i), 1'b1, 5'd0, $urandom, 1'b1, 5'd0, $urandom, $urandom);
            step();
        end
        idle();
        checks++; if (lsq_full !== 1'b1 || mq.size() != 8) begin errors++; $display("FAIL fill_full: got full=%b model=%0d want 1/8", lsq_full, mq.size()); end
        in_flight_mem = 0;
        for (int i = 0; i < 30; i++) begin
            if (i < 10) dispatch(1'($urandom), 5'(i), 1'b1, 5'd0, $urandom, 1'b1, 5'd0, $urandom, $urandom);
            else idle();
            step();
            if (i == 0) begin
                checks++; if (lsq_full !== 1'b1 || ls_q_out.rob_id_dest !== 5'd16) begin errors++; $display("FAIL full_swap: got full=%b rob=%0d want 1/16", lsq_full, ls_q_out.rob_id_dest); end
            end
            checks++; if (ls_q_out !== m_out || lsq_full !== (mq.size() == 8) || lsq_empty !== (mq.size() == 0)) begin
                errors++; $display("FAIL wrap_cyc%0d: got %h f=%b e=%b want %h n=%0d", i, ls_q_out, lsq_full, lsq_empty, m_out, mq.size());
            end
        end
    endtask

    task automatic test_inflight_order();
        logic [4:0] seen[$];
        logic       prev;
        idle(); in_flight_mem = 1;
        for (int i = 1; i <= 3; i++) begin
            dispatch(1'b1, 5'(i), 1'b1, 5'd0, $urandom, 1'b1, 5'd0, 32'h0, $urandom);
            step();
        end
        idle();
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (ls_q_out.valid !== 1'b0) begin errors++; $display("FAIL inflight_hold: got %b want 0", ls_q_out.valid); end
        end
        in_flight_mem = 0; prev = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            checks++; if (ls_q_out !== m_out) begin errors++; $display("FAIL order_model: got %h want %h", ls_q_out, m_out); end
            checks++; if (prev && ls_q_out.valid) begin errors++; $display("FAIL back_to_back: got two pulses want gap at cyc %0d", i); end
            if (ls_q_out.valid) seen.push_back(ls_q_out.rob_id_dest);
            prev = ls_q_out.valid;
        end
        checks++;
        if (seen.size() != 3 || seen[0] !== 5'd1 || seen[1] !== 5'd2 || seen[2] !== 5'd3) begin
            errors++; $display("FAIL issue_order: got %0d issues want rob 1,2,3", seen.size());
        end
    endtask

    task automatic test_flush();
        idle(); in_flight_mem = 1;
        for (int i = 0; i < 5; i++) begin
            dispatch(1'b0, 5'(20 + i), 1'b1, 5'd0, $urandom, 1'b1, 5'd0, $urandom, $urandom);
            step();
        end
        idle(); flush = 1; in_flight_mem = 0;
        step(); flush = 0;
        checks++; if (lsq_empty !== 1'b1 || ls_q_out.valid !== 1'b0) begin errors++; $display("FAIL flush_empty: got e=%b v=%b want 1/0", lsq_empty, ls_q_out.valid); end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (ls_q_out.valid !== 1'b0 || lsq_empty !== 1'b1) begin errors++; $display("FAIL flush_quiet: got v=%b e=%b want 0/1", ls_q_out.valid, lsq_empty); end
        end
    endtask

    task automatic test_mid_reset();
        dispatch(1'b1, 5'd30, 1'b1, 5'd0, 32'h40, 1'b1, 5'd0, 32'h0, 32'h0);
        step();
        dispatch(1'b1, 5'd31, 1'b1, 5'd0, 32'h44, 1'b1, 5'd0, 32'h0, 32'h0);
        step(); idle();
        checks++; if (ls_q_out.valid !== 1'b1) begin errors++; $display("FAIL pre_reset_issue: got %b want 1", ls_q_out.valid); end
        #2 rst_n = 0;
        #1;
        model_reset();
        checks++; if (ls_q_out.valid !== 1'b0 || lsq_empty !== 1'b1 || lsq_full !== 1'b0) begin
            errors++; $display("FAIL mid_reset: got v=%b e=%b f=%b want 0/1/0", ls_q_out.valid, lsq_empty, lsq_full);
        end
        rst_n = 1;
        step();
        checks++; if (ls_q_out.valid !== 1'b0 || lsq_empty !== 1'b1) begin errors++; $display("FAIL post_reset: got v=%b e=%b want 0/1", ls_q_out.valid, lsq_empty); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            idle();
            if ($urandom_range(0, 1) == 1)
                dispatch(1'($urandom), 5'($urandom), ($urandom_range(0, 2) != 0), 5'($urandom_range(0, 7)), $urandom,
                         ($urandom_range(0, 2) != 0), 5'($urandom_range(0, 7)), $urandom, $urandom);
            cdb_valid = ($urandom_range(0, 1) == 1);
            cdb_rob_id = 5'($urandom_range(0, 7));
            cdb_data = $urandom;
            flush = ($urandom_range(0, 39) == 0);
            in_flight_mem = ($urandom_range(0, 2) == 0);
            step();
            checks++;
            if (ls_q_out !== m_out || lsq_full !== (mq.size() == 8) || lsq_empty !== (mq.size() == 0)) begin
                errors++; $display("FAIL rand_cyc%0d: got %h f=%b e=%b want %h n=%0d", i, ls_q_out, lsq_full, lsq_empty, m_out, mq.size());
            end
        end
        idle(); in_flight_mem = 0;
    endtask

    initial begin
        test_reset();
        test_load_issue();
        test_cdb_wakeup();
        test_bypass();
        test_full_wrap();
        test_inflight_order();
        test_flush();
        test_mid_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
